// File: rtl/updown_step_driver.sv
// updown_step_driver: command-side driver for a 16-bit loadable up/down
// counter. It seeks to a target by single-count steps at a programmable
// pulse spacing, or jumps there with one parallel load. A position mirror
// (Pos) tracks the counter's Q, so arrival is detected without reading Q back.
//
// Command handshake: go/jump are level-sampled only while IDLE (busy low);
// there is no ready signal, and a command presented while busy is dropped.
// abort is honoured in every busy state and ends the operation at the next
// edge without a done pulse.
module updown_step_driver #(
  parameter logic [15:0] INIT     = 16'd0,
  parameter logic [7:0]  STEP_GAP = 8'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        jump,
  input  logic        abort,
  input  logic [15:0] target,
  output logic        Up,
  output logic        Dw,
  output logic        LD,
  output logic [15:0] Din,
  output logic [15:0] Pos,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Reload value for the gap counter; only used when STEP_GAP is nonzero.
  localparam logic [7:0] GAP_RELOAD = STEP_GAP - 8'd1;

  state_t      state, state_n;
  logic [15:0] tgt, tgt_n;
  logic [15:0] pos_n;
  logic        dir_up, dir_up_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        done_n;
  logic [15:0] pos_step;

  // Position after the step taken in the current STEP cycle.
  always_comb begin
    pos_step = dir_up ? (Pos + 16'd1) : (Pos - 16'd1);
  end

  // Next-state and next-register decode; the counter acts on Up/Dw/LD at the
  // same edge that Pos is updated, which keeps Pos equal to Q.
  always_comb begin
    state_n   = state;
    tgt_n     = tgt;
    pos_n     = Pos;
    dir_up_n  = dir_up;
    gap_cnt_n = gap_cnt;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (jump) begin
          tgt_n   = target;
          state_n = LOAD;
        end else if (go) begin
          tgt_n = target;
          if (target == Pos) begin
            done_n = 1'b1;
          end else begin
            dir_up_n = (target > Pos);
            state_n  = STEP;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          pos_n   = tgt;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      STEP: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          pos_n = pos_step;
          if (pos_step == tgt) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else if (STEP_GAP == 8'd0) begin
            state_n = STEP;
          end else begin
            gap_cnt_n = GAP_RELOAD;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (gap_cnt == 8'd0) begin
          state_n = STEP;
        end else begin
          gap_cnt_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt     <= INIT;
      Pos     <= INIT;
      dir_up  <= 1'b0;
      gap_cnt <= 8'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      tgt     <= tgt_n;
      Pos     <= pos_n;
      dir_up  <= dir_up_n;
      gap_cnt <= gap_cnt_n;
      done    <= done_n;
    end
  end

  // Moore command decode; the three commands are mutually exclusive by state.
  always_comb begin
    Up        = (state == STEP) & dir_up;
    Dw        = (state == STEP) & ~dir_up;
    LD        = (state == LOAD);
    busy      = (state != IDLE);
    Din       = tgt;
    dbg_state = state;
  end

endmodule

// File: tb/tb_updown_step_driver.sv
// Bench for updown_step_driver: a transaction-level model expands each
// accepted command into its expected per-cycle output trace, and a small
// counter model driven by the DUT's commands stands in for the real counter.
module tb_updown_step_driver;

  localparam logic [15:0] INIT = 16'h0010;
  localparam int G = 2;
  localparam int W = 37;

  logic        clk = 1'b0;
  logic        rst, go, jump, abort;
  logic [15:0] target;
  logic        Up, Dw, LD, busy, done;
  logic [15:0] Din, Pos;
  logic [1:0]  dbg_state;

  logic        go0;
  logic [15:0] target0;
  logic        Up0, Dw0, LD0, busy0, done0;
  logic [15:0] Din0, Pos0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [15:0]  model_pos = INIT;
  logic [15:0]  model_tgt = INIT;
  logic         q_sync = 1'b1;
  logic [15:0]  q = INIT;
  logic [15:0]  q0 = INIT;

  // clock block
  always #5 clk = ~clk;

  updown_step_driver #(.INIT(INIT), .STEP_GAP(8'd2)) dut (
    .clk(clk), .rst(rst), .go(go), .jump(jump), .abort(abort), .target(target),
    .Up(Up), .Dw(Dw), .LD(LD), .Din(Din), .Pos(Pos), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  updown_step_driver #(.INIT(INIT), .STEP_GAP(8'd0)) dut0 (
    .clk(clk), .rst(rst), .go(go0), .jump(1'b0), .abort(1'b0), .target(target0),
    .Up(Up0), .Dw(Dw0), .LD(LD0), .Din(Din0), .Pos(Pos0), .busy(busy0), .done(done0),
    .dbg_state(dbg_state0)
  );

  // counter models: act on the commands at the rising edge, no reset
  always @(posedge clk) begin
    if (LD) q <= Din;
    else if (Up) q <= q + 16'd1;
    else if (Dw) q <= q - 16'd1;
    if (LD0) q0 <= Din0;
    else if (Up0) q0 <= q0 + 16'd1;
    else if (Dw0) q0 <= q0 - 16'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ent(input logic up, input logic dw, input logic ld,
                                       input logic bz, input logic dn,
                                       input logic [15:0] p, input logic [15:0] d);
    return {up, dw, ld, bz, dn, p, d};
  endfunction

  function automatic bit is_gap(input logic [W-1:0] e);
    return e[36:32] == 5'b00010;
  endfunction

  // one cycle: wait for the sample point, compare against the expected trace
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = ent(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_pos, model_tgt);
    last_exp = e;
    check("cycle", {27'd0, Up, Dw, LD, busy, done, Pos, Din}, {27'd0, e});
    if (q_sync) check("pos_eq_q", {48'd0, Pos}, {48'd0, q});
  endtask

  // expected trace of a stepped seek from the model position to t
  task automatic plan_go(input logic [15:0] t);
    logic [15:0] p;
    bit up;
    int n;
    if (t == model_pos) begin
      exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t, t));
    end else begin
      up = (t > model_pos);
      n = up ? int'(t) - int'(model_pos) : int'(model_pos) - int'(t);
      p = model_pos;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(ent(up, !up, 1'b0, 1'b1, 1'b0, p, t));
        p = up ? p + 16'd1 : p - 16'd1;
        if (i < n - 1)
          for (int j = 0; j < G; j++) exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, p, t));
      end
      exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t, t));
    end
    model_pos = t;
    model_tgt = t;
  endtask

  task automatic issue_go(input logic [15:0] t);
    go = 1'b1;
    target = t;
    plan_go(t);
    tick();
    go = 1'b0;
  endtask

  task automatic issue_jump(input logic [15:0] t);
    jump = 1'b1;
    target = t;
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, model_pos, t));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t, t));
    model_pos = t;
    model_tgt = t;
    tick();
    jump = 1'b0;
  endtask

  // abort while the last sampled cycle was a gap cycle
  task automatic do_abort();
    abort = 1'b1;
    exp_q.delete();
    model_pos = last_exp[31:16];
    tick();
    abort = 1'b0;
  endtask

  // run the planned trace out, optionally with ignored commands and aborts
  task automatic drain(input bit noise);
    while (exp_q.size() > 0) begin
      if (noise && is_gap(last_exp) && $urandom_range(0, 7) == 0) begin
        do_abort();
        break;
      end
      if (noise && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) go = 1'b1;
        else jump = 1'b1;
        target = 16'($urandom_range(0, 65535));
      end
      tick();
      go = 1'b0;
      jump = 1'b0;
    end
  endtask

  initial begin
    int off, tt;
    bit found;
    rst = 1'b1; go = 1'b0; jump = 1'b0; abort = 1'b0; target = 16'd0;
    go0 = 1'b0; target0 = 16'd0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_pos", {48'd0, Pos}, {48'd0, INIT});
    check("rst_din", {48'd0, Din}, {48'd0, INIT});
    check("rst_ctrl", {59'd0, Up, Dw, LD, busy, done}, 64'd0);
    check("rst_pos0", {48'd0, Pos0}, {48'd0, INIT});
    rst = 1'b0;

    // stepped seek up, gap 2: pulses at k+1, k+4, k+7, done at k+8
    issue_go(16'h0013);
    drain(1'b0);
    check("seek_up_q", {48'd0, q}, 64'h0013);

    // stepped seek down on the gap-0 instance
    go0 = 1'b1; target0 = 16'h000E;
    tick();
    go0 = 1'b0;
    check("g0_step1", {46'd0, Up0, Dw0, Pos0}, {46'd0, 2'b01, 16'h0010});
    tick();
    check("g0_step2", {46'd0, Up0, Dw0, Pos0}, {46'd0, 2'b01, 16'h000F});
    tick();
    check("g0_done", {45'd0, done0, busy0, Dw0, Pos0}, {45'd0, 3'b100, 16'h000E});
    check("g0_q", {48'd0, q0}, 64'h000E);
    tick();
    check("g0_done_1cyc", {62'd0, done0, busy0}, 64'd0);

    // jump to the top of the range, then a short seek down without wrap
    issue_jump(16'hFFFF);
    drain(1'b0);
    check("utc", {63'd0, q == 16'hFFFF}, 64'd1);
    issue_go(16'hFFFD);
    drain(1'b0);
    check("no_wrap_q", {48'd0, q}, 64'hFFFD);

    // zero distance, then commands pulsed during a busy seek
    issue_go(16'hFFFD);
    drain(1'b0);
    issue_go(16'hFFF8);
    go = 1'b1; target = 16'h0000;
    tick();
    go = 1'b0; jump = 1'b1; target = 16'h1111;
    tick();
    jump = 1'b0;
    drain(1'b1);

    // abort in a gap after two steps of a 0 -> 5 seek
    issue_jump(16'h0000);
    drain(1'b0);
    issue_go(16'h0005);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (is_gap(last_exp) && last_exp[31:16] == 16'h0002) found = 1'b1;
      else tick();
    end
    check("abort_setup", {63'd0, found}, 64'd1);
    if (found) do_abort();
    check("abort_pos", {48'd0, Pos}, 64'h0002);
    check("abort_q", {48'd0, q}, 64'h0002);
    tick();

    // reset in the middle of a seek, then resynchronise with a jump
    issue_go(16'h0030);
    repeat (5) tick();
    rst = 1'b1;
    exp_q.delete();
    model_pos = INIT;
    model_tgt = INIT;
    q_sync = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_pos", {48'd0, Pos}, {48'd0, INIT});
    tick();
    issue_jump(16'h1234);
    drain(1'b0);
    q_sync = 1'b1;
    check("resync_q", {48'd0, q}, 64'h1234);

    // randomized commands
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1: issue_jump(16'($urandom_range(0, 65535)));
        2: begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
        end
        default: begin
          off = int'($urandom_range(0, 12)) - 6;
          tt = int'(model_pos) + off;
          if (tt < 0 || tt > 65535) tt = int'(model_pos) - off;
          issue_go(16'(tt));
        end
      endcase
      drain(1'b1);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
